// File: rtl/apuf_eval_sequencer.sv
// Arbiter-PUF challenge evaluation sequencer: drives a challenge, launches N_EVAL
// evaluations and returns a majority-voted response. Optional: APUF_SEQ_STABILITY_EN.
module apuf_eval_sequencer #(
  parameter int CHAL_W      = 64,
  parameter int N_EVAL      = 15,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 255,
  localparam int CNT_W      = $clog2(N_EVAL + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CHAL_W-1:0] req_chal,
  output logic [CHAL_W-1:0] challenge,
  output logic              tigSignal,
  input  logic              respReady,
  input  logic              respBit,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_bit,
  output logic [CNT_W-1:0]  rsp_ones,
  output logic              rsp_timeout,
  output logic              rsp_stable
);

  // state   | meaning
  // IDLE    | waiting for a challenge request
  // SETTLE  | challenge settling, trigger low
  // LAUNCH  | trigger armed for the next evaluation
  // WAIT    | trigger high, waiting for the arbiter strobe
  // RELEASE | trigger low, delay lines discharging
  // DONE    | result presented until accepted
  typedef enum logic [2:0] {
    IDLE, SETTLE, LAUNCH, WAIT, RELEASE, DONE
  } state_t;

  localparam logic [7:0]       SETTLE_LAST  = 8'(SETTLE_CYC - 1);
  localparam logic [15:0]      TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] N_MAX        = CNT_W'(N_EVAL);
  localparam logic [CNT_W-1:0] HALF         = CNT_W'(N_EVAL / 2);

  state_t              state, state_nx;
  logic [7:0]          settle_cnt, settle_nx;
  logic [15:0]         wait_cnt, wait_nx;
  logic [CNT_W-1:0]    eval_cnt, eval_nx;
  logic [CNT_W-1:0]    ones, ones_nx;
  logic                timeout_q, timeout_nx;
  logic [CHAL_W-1:0]   chal_q, chal_nx;
  logic                tig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      wait_cnt   <= '0;
      eval_cnt   <= '0;
      ones       <= '0;
      timeout_q  <= 1'b0;
      chal_q     <= '0;
      tig_q      <= 1'b0;
    end else begin
      state      <= state_nx;
      settle_cnt <= settle_nx;
      wait_cnt   <= wait_nx;
      eval_cnt   <= eval_nx;
      ones       <= ones_nx;
      timeout_q  <= timeout_nx;
      chal_q     <= chal_nx;
      // Trigger is high for exactly the cycles spent in WAIT.
      tig_q      <= (state_nx == WAIT);
    end
  end

  always_comb begin
    state_nx   = state;
    settle_nx  = settle_cnt;
    wait_nx    = wait_cnt;
    eval_nx    = eval_cnt;
    ones_nx    = ones;
    timeout_nx = timeout_q;
    chal_nx    = chal_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          chal_nx    = req_chal;
          eval_nx    = '0;
          ones_nx    = '0;
          timeout_nx = 1'b0;
          settle_nx  = '0;
          state_nx   = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_nx = '0;
          state_nx  = LAUNCH;
        end else begin
          settle_nx = settle_cnt + 8'd1;
        end
      end
      LAUNCH: begin
        wait_nx  = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        if (respReady) begin
          if (respBit && (ones != N_MAX)) ones_nx = ones + 1'b1;
          if (eval_cnt != N_MAX) eval_nx = eval_cnt + 1'b1;
          settle_nx = '0;
          state_nx  = RELEASE;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          timeout_nx = 1'b1;
          state_nx   = DONE;
        end else begin
          wait_nx = wait_cnt + 16'd1;
        end
      end
      RELEASE: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_nx = '0;
          state_nx  = (eval_cnt == N_MAX) ? DONE : LAUNCH;
        end else begin
          settle_nx = settle_cnt + 8'd1;
        end
      end
      DONE: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign req_ready   = (state == IDLE);
  assign rsp_valid   = (state == DONE);
  assign rsp_bit     = (state == DONE) && (ones > HALF) && !timeout_q;
  assign rsp_ones    = ones;
  assign rsp_timeout = timeout_q;
  assign challenge   = chal_q;
  assign tigSignal   = tig_q;

`ifdef APUF_SEQ_STABILITY_EN
  assign rsp_stable = (state == DONE) && !timeout_q && ((ones == '0) || (ones == N_MAX));
`else
  assign rsp_stable = 1'b0;
`endif

endmodule
